// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the instruction/data sram-like port arbiter.
package sram_like_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } lock_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_src_fifo.sv
// Ordered 1-bit FIFO recording which master owns each in-flight request.
module sram_src_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             push_en, pop_en;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign dout    = mem_q[rptr_q];
    assign count   = cnt_q;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wptr_q] <= din;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop_en)
                rptr_q <= rptr_q + 1'b1;
            if (push_en && !pop_en)
                cnt_q <= cnt_q + 1'b1;
            else if (pop_en && !push_en)
                cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates inst/data sram-like masters onto one port; data first, with a
// starvation limiter, and in-order return of dataok/rdata to the issuer.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           inst_sram_req,
    input  logic                           inst_sram_wr,
    input  logic [1:0]                     inst_sram_size,
    input  logic [31:0]                    inst_sram_addr,
    input  logic [31:0]                    inst_sram_wdata,
    output logic                           inst_sram_addrok,
    output logic                           inst_sram_dataok,
    output logic [31:0]                    inst_sram_rdata,
    input  logic                           data_sram_req,
    input  logic                           data_sram_wr,
    input  logic [1:0]                     data_sram_size,
    input  logic [31:0]                    data_sram_addr,
    input  logic [31:0]                    data_sram_wdata,
    output logic                           data_sram_addrok,
    output logic                           data_sram_dataok,
    output logic [31:0]                    data_sram_rdata,
    output logic                           mem_req,
    output logic                           mem_wr,
    output logic [1:0]                     mem_size,
    output logic [31:0]                    mem_addr,
    output logic [31:0]                    mem_wdata,
    input  logic [31:0]                    mem_rdata,
    input  logic                           mem_addrok,
    input  logic                           mem_dataok,
    output logic [$clog2(OUTSTANDING):0]   outstanding,
    output logic                           protocol_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    lock_e         lock_q, lock_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          err_q, err_d;
    logic          gnt_vld, gnt_src;
    logic          full, empty, head, hs, pop;
    sram_req_t     inst_r, data_r, sel;

    assign inst_r = '{inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wdata};
    assign data_r = '{data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wdata};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q   <= IDLE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Grant: a held lock overrides the priority choice made in IDLE.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_src = SRC_INST;
        case (lock_q)
            LOCK_I: begin gnt_vld = 1'b1; gnt_src = SRC_INST; end
            LOCK_D: begin gnt_vld = 1'b1; gnt_src = SRC_DATA; end
            default: begin
                if (starve_q == STARVE_MAX && inst_sram_req) begin
                    gnt_vld = 1'b1; gnt_src = SRC_INST;
                end else if (data_sram_req) begin
                    gnt_vld = 1'b1; gnt_src = SRC_DATA;
                end else if (inst_sram_req) begin
                    gnt_vld = 1'b1; gnt_src = SRC_INST;
                end
            end
        endcase
        sel       = (gnt_src == SRC_DATA) ? data_r : inst_r;
        mem_req   = resetn & gnt_vld & sel.req & ~full;
        mem_wr    = gnt_vld & sel.wr;
        mem_size  = gnt_vld ? sel.size  : 2'd0;
        mem_addr  = gnt_vld ? sel.addr  : 32'd0;
        mem_wdata = gnt_vld ? sel.wdata : 32'd0;
    end

    assign hs = mem_req & mem_addrok;

    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            IDLE:    if (mem_req && !mem_addrok)
                         lock_d = (gnt_src == SRC_DATA) ? LOCK_D : LOCK_I;
            default: if (hs) lock_d = IDLE;
        endcase

        starve_d = starve_q;
        if (!inst_sram_req || (hs && gnt_src == SRC_INST))
            starve_d = '0;
        else if (hs && starve_q != STARVE_MAX)
            starve_d = starve_q + 1'b1;

        err_d = err_q | (mem_dataok & empty);
    end

    assign pop = mem_dataok & ~empty;

    sram_src_fifo #(.DEPTH(OUTSTANDING)) u_src_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (hs),
        .din   (gnt_src),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

    assign inst_sram_addrok = hs & (gnt_src == SRC_INST);
    assign data_sram_addrok = hs & (gnt_src == SRC_DATA);
    assign inst_sram_dataok = resetn & pop & (head == SRC_INST);
    assign data_sram_dataok = resetn & pop & (head == SRC_DATA);
    assign inst_sram_rdata  = inst_sram_dataok ? mem_rdata : 32'd0;
    assign data_sram_rdata  = data_sram_dataok ? mem_rdata : 32'd0;
    assign protocol_err     = err_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios plus random traffic,
// checked against a queue-based transaction model.
module tb_sram_like_arbiter;
    localparam int OUTS = 4;
    localparam int SL   = 8;

    logic        clk = 1'b0, resetn;
    logic        inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr;
    logic [1:0]  inst_sram_size, data_sram_size, mem_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
    logic        inst_sram_addrok, inst_sram_dataok, data_sram_addrok, data_sram_dataok;
    logic [31:0] inst_sram_rdata, data_sram_rdata;
    logic        mem_req, mem_wr, mem_addrok, mem_dataok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  outstanding;
    logic        protocol_err;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(OUTS), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addrok(inst_sram_addrok), .inst_sram_dataok(inst_sram_dataok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addrok(data_sram_addrok), .data_sram_dataok(data_sram_dataok), .data_sram_rdata(data_sram_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_addrok(mem_addrok), .mem_dataok(mem_dataok),
        .outstanding(outstanding), .protocol_err(protocol_err)
    );

    int checks = 0, failures = 0;

    // Transaction model: queue of issuers (1 = data), owner of a pending
    // address phase (0 none, 1 inst, 2 data), data-grants-while-inst-waits.
    bit   m_q[$];
    int   m_owner, m_starve;
    bit   m_err;
    logic [139:0] exp_vec;
    bit   e_req, e_gd, e_ia, e_da;

    function automatic logic [139:0] dut_vec();
        return {mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_sram_addrok, data_sram_addrok,
                inst_sram_dataok, data_sram_dataok, inst_sram_rdata, data_sram_rdata, outstanding, protocol_err};
    endfunction

    task automatic model_reset();
        m_q.delete(); m_owner = 0; m_starve = 0; m_err = 0;
    endtask

    task automatic model_eval();
        bit gv, wr, id, dd;
        logic [1:0] sz;
        logic [31:0] a, w, ir, dr;
        gv = 1; e_gd = 0;
        if (m_owner == 1)                         e_gd = 0;
        else if (m_owner == 2)                    e_gd = 1;
        else if (m_starve == SL && inst_sram_req) e_gd = 0;
        else if (data_sram_req)                   e_gd = 1;
        else if (inst_sram_req)                   e_gd = 0;
        else                                      gv = 0;
        e_req = gv && (e_gd ? data_sram_req : inst_sram_req) && (m_q.size() < OUTS);
        wr = gv && (e_gd ? data_sram_wr : inst_sram_wr);
        sz = !gv ? 2'd0  : e_gd ? data_sram_size  : inst_sram_size;
        a  = !gv ? 32'd0 : e_gd ? data_sram_addr  : inst_sram_addr;
        w  = !gv ? 32'd0 : e_gd ? data_sram_wdata : inst_sram_wdata;
        e_ia = e_req && mem_addrok && !e_gd;
        e_da = e_req && mem_addrok && e_gd;
        id = 0; dd = 0; ir = 0; dr = 0;
        if (mem_dataok && m_q.size() > 0) begin
            if (m_q[0]) begin dd = 1; dr = mem_rdata; end
            else        begin id = 1; ir = mem_rdata; end
        end
        exp_vec = {e_req, wr, sz, a, w, e_ia, e_da, id, dd, ir, dr, 3'(m_q.size()), m_err};
    endtask

    task automatic model_update();
        bit hs;
        hs = e_req && mem_addrok;
        if (mem_dataok) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1;
        end
        if (hs) m_q.push_back(e_gd);
        if (m_owner == 0) begin
            if (e_req && !mem_addrok) m_owner = e_gd ? 2 : 1;
        end else if (hs) m_owner = 0;
        if (!inst_sram_req || (hs && !e_gd)) m_starve = 0;
        else if (hs && m_starve < SL) m_starve++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_inst(input bit req, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        inst_sram_req = req; inst_sram_wr = wr; inst_sram_size = 2'd2;
        inst_sram_addr = addr; inst_sram_wdata = wd;
    endtask

    task automatic set_data(input bit req, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        data_sram_req = req; data_sram_wr = wr; data_sram_size = 2'd2;
        data_sram_addr = addr; data_sram_wdata = wd;
    endtask

    task automatic set_mem(input bit aok, input bit dok, input logic [31:0] rd);
        mem_addrok = aok; mem_dataok = dok; mem_rdata = rd;
    endtask

    task automatic test_reset();
        resetn = 0;
        set_inst(1, 0, 32'hBFC0_0000, 0); set_data(1, 1, 32'h8000_0000, 32'h1234);
        set_mem(1, 1, 32'hFFFF_FFFF);
        #3;
        checks++;
        if ({mem_req, inst_sram_addrok, data_sram_addrok, inst_sram_dataok, data_sram_dataok,
             outstanding, protocol_err} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b aok=%b%b dok=%b%b outs=%0d err=%b exp all 0",
                     mem_req, inst_sram_addrok, data_sram_addrok, inst_sram_dataok, data_sram_dataok,
                     outstanding, protocol_err);
        end
        @(negedge clk);
        set_inst(0, 0, 0, 0); set_data(0, 0, 0, 0); set_mem(0, 0, 0);
        resetn = 1;
        model_reset();
        #1 model_eval();
        checks++;
        if (dut_vec() !== exp_vec) begin
            failures++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec);
        end
        tick();
    endtask

    task automatic test_inst_only();
        int peak = 0;
        bit dseen = 0;
        for (int c = 0; c < 7; c++) begin
            set_inst(c < 4, 0, 32'hBFC0_0000 + 32'(4 * c), 0);
            set_data(0, 0, 0, 0);
            set_mem(1, c >= 2 && c < 6, 32'h1111_0000 + 32'(c - 2));
            #1 model_eval();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL inst_only cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
            end
            if (c < 4) begin
                checks++;
                if (inst_sram_addrok !== 1'b1) begin
                    failures++; $display("FAIL inst_only_addrok cyc=%0d got=%b exp=1", c, inst_sram_addrok);
                end
            end
            if (c >= 2 && c < 6) begin
                checks++;
                if (inst_sram_dataok !== 1'b1 || inst_sram_rdata !== 32'h1111_0000 + 32'(c - 2)) begin
                    failures++;
                    $display("FAIL inst_only_rdata cyc=%0d got dok=%b rdata=%h exp dok=1 rdata=%h",
                             c, inst_sram_dataok, inst_sram_rdata, 32'h1111_0000 + 32'(c - 2));
                end
            end
            if (int'(outstanding) > peak) peak = int'(outstanding);
            if (data_sram_dataok === 1'b1) dseen = 1;
            tick();
        end
        checks++;
        if (peak != 2 || dseen) begin
            failures++; $display("FAIL inst_only_peak got peak=%0d data_dok_seen=%b exp peak=2 seen=0", peak, dseen);
        end
    endtask

    task automatic test_both();
        for (int c = 0; c < 5; c++) begin
            set_inst(c < 2, 0, 32'hBFC0_0100, 0);
            set_data(c == 0, 1, 32'h8000_1000, 32'hDEAD_BEEF);
            set_mem(1, c == 2 || c == 3, c == 2 ? 32'hA5A5_0001 : 32'h5A5A_0002);
            #1 model_eval();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL both cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
            end
            checks++;
            case (c)
                0: if (!(data_sram_addrok === 1'b1 && inst_sram_addrok === 1'b0 && mem_addr === 32'h8000_1000 &&
                         mem_wr === 1'b1 && mem_wdata === 32'hDEAD_BEEF)) begin
                       failures++; $display("FAIL both_data_first got addr=%h daok=%b exp addr=80001000 daok=1", mem_addr, data_sram_addrok);
                   end
                1: if (inst_sram_addrok !== 1'b1 || mem_addr !== 32'hBFC0_0100) begin
                       failures++; $display("FAIL both_inst_next got iaok=%b addr=%h exp 1 bfc00100", inst_sram_addrok, mem_addr);
                   end
                2: if (data_sram_dataok !== 1'b1 || data_sram_rdata !== 32'hA5A5_0001 || inst_sram_dataok !== 1'b0) begin
                       failures++; $display("FAIL both_dok_data got ddok=%b rdata=%h exp 1 a5a50001", data_sram_dataok, data_sram_rdata);
                   end
                3: if (inst_sram_dataok !== 1'b1 || inst_sram_rdata !== 32'h5A5A_0002 || data_sram_dataok !== 1'b0) begin
                       failures++; $display("FAIL both_dok_inst got idok=%b rdata=%h exp 1 5a5a0002", inst_sram_dataok, inst_sram_rdata);
                   end
                default: if (outstanding !== 3'd0) begin
                       failures++; $display("FAIL both_drained got outs=%0d exp 0", outstanding);
                   end
            endcase
            tick();
        end
    endtask

    task automatic test_lock();
        for (int c = 0; c < 8; c++) begin
            set_inst(c < 4, 0, 32'hBFC0_0200, 0);
            set_data(c >= 1 && c < 5, 0, 32'h8000_2000, 0);
            set_mem(c >= 3, c == 5 || c == 6, 32'h0000_0C00 + 32'(c));
            #1 model_eval();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL lock cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
            end
            if (c < 4) begin
                checks++;
                if (mem_addr !== 32'hBFC0_0200 || data_sram_addrok !== 1'b0 || inst_sram_addrok !== (c == 3)) begin
                    failures++;
                    $display("FAIL lock_hold cyc=%0d got addr=%h iaok=%b daok=%b exp addr=bfc00200 iaok=%b daok=0",
                             c, mem_addr, inst_sram_addrok, data_sram_addrok, c == 3);
                end
            end
            if (c == 4) begin
                checks++;
                if (data_sram_addrok !== 1'b1 || mem_addr !== 32'h8000_2000) begin
                    failures++; $display("FAIL lock_data_after got daok=%b addr=%h exp 1 80002000", data_sram_addrok, mem_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_full();
        int n = 0;
        for (int c = 0; c < 12; c++) begin
            set_inst(0, 0, 0, 0);
            set_data(c <= 6, 0, 32'h8000_3000 + 32'(4 * n), 0);
            set_mem(1, c == 5 || c == 6 || (c >= 8 && c <= 10), 32'hF000_0000 + 32'(c));
            #1 model_eval();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL full cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
            end
            if (c == 4 || c == 5) begin
                checks++;
                if (mem_req !== 1'b0 || outstanding !== 3'd4) begin
                    failures++; $display("FAIL full_block cyc=%0d got req=%b outs=%0d exp req=0 outs=4", c, mem_req, outstanding);
                end
            end
            if (c == 6 || c == 7) begin
                checks++;
                if (outstanding !== 3'd3 || (c == 6 && data_sram_addrok !== 1'b1)) begin
                    failures++; $display("FAIL full_pushpop cyc=%0d got outs=%0d daok=%b exp outs=3", c, outstanding, data_sram_addrok);
                end
            end
            if (e_da) n++;
            tick();
        end
    endtask

    task automatic test_starve();
        bit seq[$];
        int ni = 0, nd = 0, first_i;
        for (int c = 0; c < 19; c++) begin
            set_inst(1, 0, 32'hBFC0_0300 + 32'(4 * ni), 0);
            set_data(1, 0, 32'h8000_4000 + 32'(4 * nd), 0);
            set_mem(1, m_q.size() > 0, $urandom);
            #1 model_eval();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL starve cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
            end
            if (inst_sram_addrok === 1'b1) seq.push_back(1'b0);
            else if (data_sram_addrok === 1'b1) seq.push_back(1'b1);
            if (e_ia) ni++;
            if (e_da) nd++;
            tick();
        end
        first_i = -1;
        for (int i = 0; i < seq.size(); i++) if (!seq[i] && first_i < 0) first_i = i;
        checks++;
        if (seq.size() != 19 || first_i != SL || !seq[SL+1] || seq[2*SL+1]) begin
            failures++;
            $display("FAIL starve_pattern got grants=%0d first_inst=%0d exp grants=19 first_inst=%0d", seq.size(), first_i, SL);
        end
        for (int c = 0; c < 3; c++) begin
            set_inst(0, 0, 0, 0); set_data(0, 0, 0, 0);
            set_mem(0, m_q.size() > 0, $urandom);
            #1 model_eval();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL starve_drain cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_protocol_err();
        for (int c = 0; c < 4; c++) begin
            set_inst(c == 2, 0, 32'hBFC0_0400, 0);
            set_data(0, 0, 0, 0);
            set_mem(c == 2, c == 0, 32'h0BAD_0BAD);
            #1 model_eval();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL perr cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
            end
            if (c > 0) begin
                checks++;
                if (protocol_err !== 1'b1 || inst_sram_dataok !== 1'b0) begin
                    failures++; $display("FAIL perr_sticky cyc=%0d got err=%b exp 1", c, protocol_err);
                end
            end
            tick();
        end
        #2 resetn = 0;
        #1;
        checks++;
        if (protocol_err !== 1'b0 || outstanding !== 3'd0) begin
            failures++; $display("FAIL perr_async_reset got err=%b outs=%0d exp 0 0", protocol_err, outstanding);
        end
        @(negedge clk);
        resetn = 1;
        model_reset();
        set_mem(0, 0, 0);
        #1 model_eval();
        checks++;
        if (dut_vec() !== exp_vec) begin
            failures++; $display("FAIL perr_after_reset got=%h exp=%h", dut_vec(), exp_vec);
        end
        tick();
    endtask

    task automatic test_random();
        bit ip = 0, dp = 0, iw = 0, dw = 0;
        logic [31:0] ia = 0, iwd = 0, da = 0, dwd = 0;
        for (int c = 0; c < 400; c++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1; iw = $urandom_range(0, 1); ia = $urandom; iwd = $urandom;
            end
            if (!dp && $urandom_range(0, 1) == 0) begin
                dp = 1; dw = $urandom_range(0, 1); da = $urandom; dwd = $urandom;
            end
            set_inst(ip, iw, ia, iwd);
            set_data(dp, dw, da, dwd);
            set_mem($urandom_range(0, 3) != 0, m_q.size() > 0 && $urandom_range(0, 1) == 1, $urandom);
            #1 model_eval();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
            end
            if (e_ia) ip = 0;
            if (e_da) dp = 0;
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            set_inst(ip, iw, ia, iwd); set_data(dp, dw, da, dwd);
            set_mem(1, m_q.size() > 0, $urandom);
            #1 model_eval();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
            end
            if (e_ia) ip = 0;
            if (e_da) dp = 0;
            tick();
        end
    endtask

    initial begin
        model_reset();
        e_req = 0; e_gd = 0; e_ia = 0; e_da = 0;
        test_reset();
        test_inst_only();
        test_both();
        test_lock();
        test_full();
        test_starve();
        test_protocol_err();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the CPU's instruction and data sram-like masters.
- Sits between mycpu's inst_sram_*/data_sram_* ports and the downstream bridge or memory.
- Data has priority over instruction. A starvation limiter guarantees instruction fetch progress.
- An in-order source-tracking FIFO returns each dataok/rdata to the master that issued the request.

Parameters:
- OUTSTANDING, 4, maximum in-flight accepted-but-unanswered requests; power of 2, ≥2.
- STARVE_LIMIT, 8, consecutive data grants while inst_sram_req waits before one forced inst grant; ≥1.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_sram_req/wr  in  1/1  instruction master request and write flag
- inst_sram_size  in  2  instruction master access size
- inst_sram_addr/wdata  in  32/32  instruction master address and write data
- inst_sram_addrok/dataok  out  1/1  instruction master address accepted / data returned
- inst_sram_rdata  out  32  instruction master read data
- data_sram_req/wr/size/addr/wdata  in  1/1/2/32/32  data master request, same meaning as inst_*
- data_sram_addrok/dataok  out  1/1  data master address accepted / data returned
- data_sram_rdata  out  32  data master read data
- mem_req/wr  out  1/1  shared downstream request and write flag
- mem_size  out  2  shared downstream access size
- mem_addr/wdata  out  32/32  shared downstream address and write data
- mem_rdata  in  32  downstream read data
- mem_addrok/mem_dataok  in  1/1  downstream address accepted / data returned
- outstanding  out  $clog2(OUTSTANDING)+1  current tracker occupancy
- protocol_err  out  1  sticky error flag

Behaviour:
- Reset (resetn low, async):
  - tracker pointers and count = 0; lock = IDLE; starve counter = 0; protocol_err = 0.
  - mem_req, all addrok and all dataok outputs forced 0 combinationally while resetn is low.
- Lock FSM, states IDLE, LOCK_I, LOCK_D:
  - IDLE: grant is chosen combinationally.
    - starve counter == STARVE_LIMIT and inst_sram_req → INST.
    - else data_sram_req → DATA.
    - else inst_sram_req → INST.
  - mem_req = granted req & ~full.
  - If mem_req && !mem_addrok, go to LOCK_I or LOCK_D. The grant and all mem_* fields are frozen on that master until mem_addrok, then return to IDLE.
  - Handshake in IDLE with same-cycle addrok stays in IDLE.
- Downstream request fields: mem_wr/size/addr/wdata are a pure mux of the granted master (all 0 when no grant).
- addrok routing: inst_sram_addrok = mem_addrok & mem_req & grant==INST; data_sram_addrok likewise. Zero latency added.
- Starve counter:
  - +1 on each data handshake while inst_sram_req is high, saturating at STARVE_LIMIT.
  - cleared on any inst handshake, or when inst_sram_req is low.
- Tracker FIFO, 1-bit source entries (0 = inst, 1 = data), depth OUTSTANDING:
  - push on mem_req & mem_addrok.
  - pop on mem_dataok; the head selects which master gets dataok and rdata = mem_rdata (same cycle, combinational). The other master's dataok = 0 and its rdata = 0.
  - push and pop in the same cycle: count unchanged, both pointers advance and wrap modulo OUTSTANDING.
  - full (count == OUTSTANDING): mem_req = 0. A lock already taken persists but stays deasserted until a pop frees space.
  - mem_dataok while empty: dropped, no master dataok, protocol_err set (sticky until reset).
  - mem_addrok without mem_req: ignored.
- Responses are in order; no ID reordering is supported.
- Reset mid-operation: all in-flight tracking is discarded. Downstream shares resetn, so no stale dataok is expected; any that arrives sets protocol_err.

Decomposition:
- Shared package:
  - SRC_INST = 1'b0, SRC_DATA = 1'b1.
  - lock state encoding IDLE/LOCK_I/LOCK_D.
  - sram-like size codes 0 = byte, 1 = half, 2 = word.
- One natural sub-module, sram_src_fifo: parameterised 1-bit-wide ordered FIFO with push/pop/full/empty/count. The arbiter holds the FSM, muxes and starve counter.

Test Plan:
- Inst only, mem_addrok=1 every cycle, dataok 2 cycles later:
  - 4 fetches at 0xBFC00000+4n → inst_sram_addrok each cycle.
  - outstanding peaks at 2; rdata 0x11110000+n routed only to inst; data_sram_dataok never asserted.
- Both masters request in the same cycle, addrok=1:
  - data granted first (addr 0x80001000, wr=1, wdata 0xDEADBEEF); inst granted next cycle.
  - dataok order DATA then INST with rdata delivered to the matching master.
- mem_addrok held 0 for 3 cycles while inst is locked, data_sram_req rising mid-lock:
  - mem_addr stays at the inst addr the whole time; inst handshake completes first; data is granted only after it.
- OUTSTANDING=4, addrok=1, dataok withheld:
  - after 4 handshakes mem_req=0 and outstanding=4.
  - one dataok → count 3, next request accepted the following cycle.
  - simultaneous push+pop keeps count at 3.
- Continuous data requests with inst_sram_req held high, STARVE_LIMIT=8:
  - exactly 8 data grants, then 1 inst grant, then data resumes; counter cleared.
- mem_dataok pulse with empty tracker → protocol_err=1 and stays 1; resetn low clears it to 0 and outstanding to 0 asynchronously.
